// File: rtl/jtframe_sdram_pkg.sv
// Shared types for the SDRAM request scheduler: FSM states and request sources.
package jtframe_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    REFRESH
  } state_t;

  typedef enum logic [2:0] {
    BA0,
    BA1,
    BA2,
    BA3,
    PROG
  } src_t;

  // Bits [3:0] map to the bank handshakes, bit 4 to the prog port
  function automatic logic [4:0] src_onehot(input src_t s);
    return 5'b00001 << s;
  endfunction

endpackage

// File: rtl/jtframe_rr_arb4.sv
// Combinational 4-way round-robin pick, searching from last+1 upward.
module jtframe_rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt,
  output logic       any
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/jtframe_sdram_sched.sv
// Arbitrates four bank ports, the download port and periodic refresh onto one
// SDRAM engine command channel, one command in flight at a time.
module jtframe_sdram_sched
  import jtframe_sdram_pkg::*;
#(
  parameter int SDRAMW = 23,
  parameter int REFCNT = 750
) (
  input  logic              clk_rom,
  input  logic              rst,
  input  logic              prog_en,
  input  logic [SDRAMW-1:0] ba0_addr,
  input  logic [SDRAMW-1:0] ba1_addr,
  input  logic [SDRAMW-1:0] ba2_addr,
  input  logic [SDRAMW-1:0] ba3_addr,
  input  logic [3:0]        ba_rd,
  input  logic [3:0]        ba_wr,
  output logic [3:0]        ba_ack,
  output logic [3:0]        ba_dst,
  output logic [3:0]        ba_rdy,
  input  logic [SDRAMW-1:0] prog_addr,
  input  logic              prog_rd,
  input  logic              prog_we,
  output logic              prog_ack,
  output logic              prog_dst,
  output logic              prog_rdy,
  output logic              eng_req,
  output logic              eng_ref,
  output logic              eng_wr,
  output logic [1:0]        eng_ba,
  output logic [SDRAMW-1:0] eng_addr,
  input  logic              eng_ack,
  input  logic              eng_dst,
  input  logic              eng_done
);

  localparam logic [9:0] REF_TOP = 10'(REFCNT - 1);

  state_t            state, state_nx;
  src_t              src;
  logic [1:0]        last_grant;
  logic [9:0]        ref_cnt;
  logic              ref_pend, ref_acked;
  logic              ack_q, rdy_q;
  logic [3:0]        bank_req;
  logic [1:0]        gnt;
  logic              any;
  logic              prog_go;
  logic [SDRAMW-1:0] bank_addr;
  logic [4:0]        ack_oh, dst_oh, rdy_oh;
  logic              unused_wr;

  // Writes are only wired for bank 0
  assign bank_req  = ba_rd | {3'b000, ba_wr[0]};
  assign unused_wr = |ba_wr[3:1];
  assign prog_go   = prog_rd | prog_we;

  jtframe_rr_arb4 u_arb (
    .req  (bank_req),
    .last (last_grant),
    .gnt  (gnt),
    .any  (any)
  );

  always_comb begin
    unique case (gnt)
      2'd0:    bank_addr = ba0_addr;
      2'd1:    bank_addr = ba1_addr;
      2'd2:    bank_addr = ba2_addr;
      default: bank_addr = ba3_addr;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (ref_pend)                    state_nx = REFRESH;
        else if (prog_en ? prog_go : any) state_nx = ISSUE;
      end
      ISSUE:   if (eng_ack)               state_nx = WAIT;
      WAIT:    if (eng_done)              state_nx = IDLE;
      REFRESH: if (ref_acked && eng_done) state_nx = IDLE;
      default:                            state_nx = IDLE;
    endcase
    eng_req = (state == ISSUE) || (state == REFRESH && !ref_acked);
    eng_ref = (state == REFRESH);
    ack_oh  = ack_q ? src_onehot(src) : '0;
    rdy_oh  = rdy_q ? src_onehot(src) : '0;
    dst_oh  = (state == WAIT && eng_dst) ? src_onehot(src) : '0;
  end

  assign ba_ack   = ack_oh[3:0];
  assign ba_dst   = dst_oh[3:0];
  assign ba_rdy   = rdy_oh[3:0];
  assign prog_ack = ack_oh[4];
  assign prog_dst = dst_oh[4];
  assign prog_rdy = rdy_oh[4];

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      state      <= IDLE;
      src        <= BA0;
      last_grant <= 2'd3;
      ref_cnt    <= '0;
      ref_pend   <= 1'b0;
      ref_acked  <= 1'b0;
      ack_q      <= 1'b0;
      rdy_q      <= 1'b0;
      eng_wr     <= 1'b0;
      eng_ba     <= '0;
      eng_addr   <= '0;
    end else begin
      state <= state_nx;
      ack_q <= (state == ISSUE) && eng_ack;
      rdy_q <= (state == WAIT) && eng_done;

      if (state == IDLE) begin
        ref_acked <= 1'b0;
        if (ref_pend) begin
          eng_wr <= 1'b0;
        end else if (prog_en) begin
          if (prog_go) begin
            src      <= PROG;
            eng_ba   <= '0;
            eng_wr   <= prog_we;
            eng_addr <= prog_addr;
          end
        end else if (any) begin
          src      <= src_t'({1'b0, gnt});
          eng_ba   <= gnt;
          eng_wr   <= (gnt == 2'd0) && ba_wr[0];
          eng_addr <= bank_addr;
        end
      end

      // Only the first ack of a refresh restarts the interval
      if (state == REFRESH && eng_ack && !ref_acked) begin
        ref_acked <= 1'b1;
        ref_cnt   <= '0;
        ref_pend  <= 1'b0;
      end else if (ref_cnt != REF_TOP) begin
        ref_cnt <= ref_cnt + 10'd1;
        if (ref_cnt + 10'd1 == REF_TOP) ref_pend <= 1'b1;
      end

      if (state == WAIT && eng_done && src != PROG) last_grant <= src[1:0];
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_sched.sv
// Scoreboard bench for jtframe_sdram_sched: expected engine commands queued by
// the stimulus, then matched against commands, acks, dsts and rdys seen.
module tb_jtframe_sdram_sched;

  localparam int AW = 23;

  typedef struct packed {
    logic [27:0] cmd;  // {valid, ref, wr, ba, addr}
    logic [4:0]  oh;   // {prog, bank[3:0]}
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, prog_en, prog_rd, prog_we;
  logic [AW-1:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr, prog_addr;
  logic [3:0]    ba_rd, ba_wr, ba_ack, ba_dst, ba_rdy;
  logic          prog_ack, prog_dst, prog_rdy;
  logic          eng_req, eng_ref, eng_wr, eng_ack, eng_dst, eng_done;
  logic [1:0]    eng_ba;
  logic [AW-1:0] eng_addr;

  logic          rst_r;
  logic [3:0]    ba_rd_r, ba_ack_r, ba_dst_r, ba_rdy_r;
  logic          prog_ack_r, prog_dst_r, prog_rdy_r;
  logic          eng_req_r, eng_ref_r, eng_wr_r, eng_ack_r, eng_dst_r, eng_done_r;
  logic [1:0]    eng_ba_r;
  logic [AW-1:0] eng_addr_r;

  int n_checks = 0;
  int n_errors = 0;
  int n_ack = 0, n_rdy = 0;
  int cyc_r = 0, n_ref_r = 0, ref_a1 = 0, ref_a2 = 0;
  logic req_seen = 1'b0;
  logic [4:0] cur_oh = '0;
  exp_t exp_q[$];
  logic [4:0] ack_exp[$], rdy_exp[$];
  logic [63:0] outs;

  always #5 clk = ~clk;

  assign outs = 64'({eng_req, eng_ref, eng_wr, eng_ba, eng_addr, ba_ack, ba_dst, ba_rdy,
                     prog_ack, prog_dst, prog_rdy});

  jtframe_sdram_sched dut (
    .clk_rom(clk), .rst(rst), .prog_en(prog_en),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy),
    .prog_addr(prog_addr), .prog_rd(prog_rd), .prog_we(prog_we),
    .prog_ack(prog_ack), .prog_dst(prog_dst), .prog_rdy(prog_rdy),
    .eng_req(eng_req), .eng_ref(eng_ref), .eng_wr(eng_wr), .eng_ba(eng_ba),
    .eng_addr(eng_addr), .eng_ack(eng_ack), .eng_dst(eng_dst), .eng_done(eng_done)
  );

  jtframe_sdram_sched #(.REFCNT(16)) dut_ref (
    .clk_rom(clk), .rst(rst_r), .prog_en(1'b0),
    .ba0_addr(23'h000010), .ba1_addr(23'h000020), .ba2_addr(23'h000030), .ba3_addr(23'h000040),
    .ba_rd(ba_rd_r), .ba_wr(4'b0000), .ba_ack(ba_ack_r), .ba_dst(ba_dst_r), .ba_rdy(ba_rdy_r),
    .prog_addr(23'h0), .prog_rd(1'b0), .prog_we(1'b0),
    .prog_ack(prog_ack_r), .prog_dst(prog_dst_r), .prog_rdy(prog_rdy_r),
    .eng_req(eng_req_r), .eng_ref(eng_ref_r), .eng_wr(eng_wr_r), .eng_ba(eng_ba_r),
    .eng_addr(eng_addr_r), .eng_ack(eng_ack_r), .eng_dst(eng_dst_r), .eng_done(eng_done_r)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic r, input logic w, input logic [1:0] ba,
                              input logic [AW-1:0] a, input logic [4:0] oh);
    exp_t e;
    e.cmd = {1'b1, r, w, ba, a};
    e.oh  = oh;
    return e;
  endfunction

  // Engine models: ack one cycle after req is seen, dst two later, done four after ack
  initial begin
    int unsigned ph;
    ph = 0;
    eng_ack = 1'b0; eng_dst = 1'b0; eng_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      eng_ack = 1'b0; eng_dst = 1'b0; eng_done = 1'b0;
      if (ph == 0) begin
        if (eng_req) ph = 1;
      end else begin
        if (ph == 1) eng_ack  = 1'b1;
        if (ph == 3) eng_dst  = 1'b1;
        if (ph == 5) eng_done = 1'b1;
        ph = (ph == 5) ? 0 : ph + 1;
      end
    end
  end

  initial begin
    int unsigned ph;
    ph = 0;
    eng_ack_r = 1'b0; eng_dst_r = 1'b0; eng_done_r = 1'b0;
    forever begin
      @(posedge clk); #1;
      eng_ack_r = 1'b0; eng_dst_r = 1'b0; eng_done_r = 1'b0;
      if (ph == 0) begin
        if (eng_req_r) ph = 1;
      end else begin
        if (ph == 1) eng_ack_r  = 1'b1;
        if (ph == 3) eng_dst_r  = 1'b1;
        if (ph == 5) eng_done_r = 1'b1;
        ph = (ph == 5) ? 0 : ph + 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [4:0] x;
    if (eng_req) req_seen = 1'b1;
    if (eng_req && eng_ack) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("cmd", 64'({1'b1, eng_ref, eng_wr, eng_ba, eng_addr}), 64'(e.cmd));
      cur_oh = e.oh;
      ack_exp.push_back(e.oh);
      rdy_exp.push_back(e.oh);
    end
    if ({prog_ack, ba_ack} != 5'b0) begin
      x = (ack_exp.size() != 0) ? ack_exp.pop_front() : 5'b0;
      n_ack++;
      check("ack", 64'({prog_ack, ba_ack}), 64'(x));
    end
    if ({prog_rdy, ba_rdy} != 5'b0) begin
      x = (rdy_exp.size() != 0) ? rdy_exp.pop_front() : 5'b0;
      n_rdy++;
      check("rdy", 64'({prog_rdy, ba_rdy}), 64'(x));
    end
    if (eng_dst) check("dst", 64'({prog_dst, ba_dst}), 64'(cur_oh));
  end

  always @(negedge clk) begin
    if (rst_r) cyc_r = 0;
    else cyc_r++;
    if (eng_req_r && eng_ack_r && eng_ref_r) begin
      n_ref_r++;
      if (n_ref_r == 1) ref_a1 = cyc_r;
      if (n_ref_r == 2) ref_a2 = cyc_r;
    end
    if (ba_ack_r != 4'b0) check("ref_inst_ack", 64'(ba_ack_r), 64'(4'b0010));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int target);
    for (int i = 0; i < 100 && n_ack < target; i++) tick(1);
    check("ack_count", 64'(n_ack), 64'(target));
  endtask

  task automatic wait_rdy(input int target);
    for (int i = 0; i < 100 && n_rdy < target; i++) tick(1);
    check("rdy_count", 64'(n_rdy), 64'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ba_rd = '0; ba_wr = '0; prog_en = 1'b0; prog_rd = 1'b0; prog_we = 1'b0;
    tick(2);
    check("reset_outs", outs, 64'd0);
    exp_q.delete(); ack_exp.delete(); rdy_exp.delete();
    n_ack = 0; n_rdy = 0; req_seen = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst_r = 1'b1; ba_rd_r = '0;
    ba0_addr = 23'h000100; ba1_addr = 23'h012211;
    ba2_addr = 23'h023322; ba3_addr = 23'h034433;
    prog_addr = 23'h7ABCDE;

    // Round robin with all banks reading
    do_reset();
    exp_q.push_back(mk(1'b0, 1'b0, 2'd0, ba0_addr, 5'b00001));
    exp_q.push_back(mk(1'b0, 1'b0, 2'd1, ba1_addr, 5'b00010));
    exp_q.push_back(mk(1'b0, 1'b0, 2'd2, ba2_addr, 5'b00100));
    exp_q.push_back(mk(1'b0, 1'b0, 2'd3, ba3_addr, 5'b01000));
    exp_q.push_back(mk(1'b0, 1'b0, 2'd0, ba0_addr, 5'b00001));
    ba_rd = 4'hF;
    wait_ack(5);
    ba_rd = '0;
    wait_rdy(5);
    tick(4);
    check("rr_left", 64'(exp_q.size() + rdy_exp.size()), 64'd0);

    // Bank 0 read+write picks the write
    do_reset();
    exp_q.push_back(mk(1'b0, 1'b1, 2'd0, ba0_addr, 5'b00001));
    ba_rd = 4'b0001; ba_wr = 4'b0001;
    wait_ack(1);
    ba_rd = '0; ba_wr = '0;
    wait_rdy(1);

    // Writes on banks 1..3 are not requests
    do_reset();
    ba_wr = 4'b1110;
    tick(20);
    check("wr_hi_no_req", 64'(req_seen), 64'd0);
    ba_wr = '0;

    // Download mode serves only prog; dropping prog_en in WAIT hands over to banks
    do_reset();
    exp_q.push_back(mk(1'b0, 1'b0, 2'd0, prog_addr, 5'b10000));
    prog_en = 1'b1; ba_rd = 4'hF; prog_rd = 1'b1;
    wait_ack(1);
    prog_rd = 1'b0; prog_en = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 2'd0, ba0_addr, 5'b00001));
    wait_ack(2);
    ba_rd = '0;
    wait_rdy(2);

    // Download write carries prog_we
    do_reset();
    exp_q.push_back(mk(1'b0, 1'b1, 2'd0, prog_addr, 5'b10000));
    prog_en = 1'b1; prog_we = 1'b1;
    wait_ack(1);
    prog_we = 1'b0; prog_en = 1'b0;
    wait_rdy(1);

    // Bank 3 drops its request right after the grant
    do_reset();
    exp_q.push_back(mk(1'b0, 1'b0, 2'd3, ba3_addr, 5'b01000));
    ba_rd = 4'b1000;
    for (int i = 0; i < 20 && !eng_req; i++) tick(1);
    check("b3_req", 64'(eng_req), 64'd1);
    ba_rd = '0;
    wait_rdy(1);

    // Reset in WAIT: outputs clear, the late done is ignored
    do_reset();
    exp_q.push_back(mk(1'b0, 1'b0, 2'd0, ba0_addr, 5'b00001));
    ba_rd = 4'b0001;
    wait_ack(1);
    ba_rd = '0;
    rst = 1'b1;
    tick(1);
    check("rst_wait_outs", outs, 64'd0);
    rst = 1'b0;
    rdy_exp.delete();
    tick(8);
    check("rst_no_rdy", 64'(n_rdy), 64'd0);
    exp_q.push_back(mk(1'b0, 1'b0, 2'd1, ba1_addr, 5'b00010));
    ba_rd = 4'b0010;
    wait_ack(2);
    ba_rd = '0;
    wait_rdy(1);
    tick(4);
    check("all_left", 64'(exp_q.size() + ack_exp.size() + rdy_exp.size()), 64'd0);

    // Refresh interval on the REFCNT=16 instance under constant bank-1 traffic
    ba_rd_r = 4'b0010;
    tick(1);
    rst_r = 1'b0;
    for (int i = 0; i < 120 && n_ref_r < 2; i++) tick(1);
    check("ref_count", 64'(n_ref_r >= 2), 64'd1);
    check("ref1_window", 64'(ref_a1 >= 17 && ref_a1 <= 28), 64'd1);
    check("ref2_interval", 64'((ref_a2 - ref_a1) >= 18 && (ref_a2 - ref_a1) <= 26), 64'd1);
    ba_rd_r = '0;
    tick(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
